// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the multi-port register file:
//   - default geometry constants (data width, address width, read ports)
//   - number of write ports (fixed at two)
//   - get_field(): extracts lane idx of width w from a packed port vector
package regfile_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_NUM_RD = 2;
    localparam int NUM_WR     = 2;

    // Widest packed port vector get_field() can handle.
    localparam int FIELD_VEC_W = 512;
    typedef logic [FIELD_VEC_W-1:0] field_vec_t;

    // Lane idx of width w, right-aligned and zero-extended.
    // Callers widen the packed vector and narrow the result with a size cast.
    function automatic field_vec_t get_field(input field_vec_t vec,
                                             input int idx,
                                             input int w);
        field_vec_t mask;
        mask = (field_vec_t'(1) << w) - field_vec_t'(1);
        return (vec >> (idx * w)) & mask;
    endfunction

endpackage

// File: rtl/regfile_if.sv
// regfile_if
// Bus between the datapath (master) and the register file (slave).
//   wr_en     [NUM_WR]          per-write-port enable, port 1 is bit 1
//   wr_addr   [NUM_WR*ADDR_W]   packed write addresses
//   wr_data   [NUM_WR*DATA_W]   packed write data
//   iss_valid                   mark iss_addr busy
//   iss_addr  [ADDR_W]          destination register being issued
//   rd_addr   [NUM_RD*ADDR_W]   packed read addresses
//   rd_data   [NUM_RD*DATA_W]   packed read data
//   rd_busy   [NUM_RD]          read register has an outstanding producer
//   busy_vec  [2**ADDR_W]       raw scoreboard state
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) ();

    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     iss_valid;
    logic [ADDR_W-1:0]        iss_addr;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [2**ADDR_W-1:0]     busy_vec;

    modport master (
        output wr_en, wr_addr, wr_data, iss_valid, iss_addr, rd_addr,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, iss_valid, iss_addr, rd_addr,
        output rd_data, rd_busy, busy_vec
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Per-register busy bits. Issue sets a bit, any enabled write port
// targeting the register clears it; a same-cycle issue wins over the clear
// because the new producer supersedes the completing one.
//   clk, reset_n      clock, asynchronous active-low reset
//   wr_en_i           per-write-port enable
//   wr_addr_i         packed write addresses
//   iss_valid_i       issue strobe
//   iss_addr_i        issued destination
//   busy_vec_o        registered busy bits
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic                     iss_valid_i,
    input  logic [ADDR_W-1:0]        iss_addr_i,
    output logic [2**ADDR_W-1:0]     busy_vec_o
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [DEPTH-1:0] set_mask;
    logic [DEPTH-1:0] clr_mask;

    always_comb begin
        set_mask = iss_valid_i ? (DEPTH'(1) << iss_addr_i) : '0;
        clr_mask = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en_i[p]) begin
                clr_mask = clr_mask |
                    (DEPTH'(1) << ADDR_W'(get_field(field_vec_t'(wr_addr_i), p, ADDR_W)));
            end
        end
        // Set is applied after clear so it takes priority.
        busy_d = (busy_q & ~clr_mask) | set_mask;
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Multi-port register file: two write ports (port 1 wins on address
// conflict), NUM_RD combinational read ports with optional write-through
// bypass, optional hardwired-zero register 0, and a busy scoreboard.
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset; clears storage and scoreboard
//            and forces all read outputs to 0 while held
//   bus      regfile_if slave modport (write, issue, read, busy signals)
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic     clk,
    input  logic     reset_n,
    regfile_if.slave bus
);

    localparam int DEPTH = 2**ADDR_W;

    logic signed [DATA_W-1:0] mem_q [DEPTH];
    logic signed [DATA_W-1:0] mem_d [DEPTH];

    logic        [ADDR_W-1:0] waddr   [NUM_WR];
    logic signed [DATA_W-1:0] wdata   [NUM_WR];
    logic        [NUM_WR-1:0] wen_eff;

    logic [DEPTH-1:0]         busy_vec;
    logic [NUM_RD*DATA_W-1:0] rd_data_pk;
    logic [NUM_RD-1:0]        rd_busy_pk;

    // Unpack write ports; writes to r0 are dropped when it is hardwired.
    always_comb begin
        for (int p = 0; p < NUM_WR; p++) begin
            waddr[p]   = ADDR_W'(get_field(field_vec_t'(bus.wr_addr), p, ADDR_W));
            wdata[p]   = DATA_W'(get_field(field_vec_t'(bus.wr_data), p, DATA_W));
            wen_eff[p] = bus.wr_en[p] && !((ZERO_REG != 0) && (waddr[p] == '0));
        end
    end

    // Ascending port order: port 1 is applied last and wins a conflict.
    always_comb begin
        mem_d = mem_q;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wen_eff[p]) begin
                mem_d[waddr[p]] = wdata[p];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en_i     (bus.wr_en),
        .wr_addr_i   (bus.wr_addr),
        .iss_valid_i (bus.iss_valid),
        .iss_addr_i  (bus.iss_addr),
        .busy_vec_o  (busy_vec)
    );

    // Read muxes. A bypassed read also masks rd_busy: the producer is
    // completing this very cycle, so the returned value is already final.
    always_comb begin : read_mux
        logic        [ADDR_W-1:0] ra;
        logic        [NUM_WR-1:0] hit;
        logic signed [DATA_W-1:0] word;
        logic                     bsy;
        rd_data_pk = '0;
        rd_busy_pk = '0;
        ra         = '0;
        hit        = '0;
        word       = '0;
        bsy        = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = ADDR_W'(get_field(field_vec_t'(bus.rd_addr), k, ADDR_W));
            for (int p = 0; p < NUM_WR; p++) begin
                hit[p] = bus.wr_en[p] && (waddr[p] == ra);
            end
            word = mem_q[ra];
            if (BYPASS != 0) begin
                for (int p = 0; p < NUM_WR; p++) begin
                    if (hit[p]) begin
                        word = wdata[p];
                    end
                end
            end
            if ((ZERO_REG != 0) && (ra == '0)) begin
                word = '0;
            end
            bsy = busy_vec[ra] && !((BYPASS != 0) && (|hit));
            // Bypass would otherwise leak write data through during reset.
            if (!reset_n) begin
                word = '0;
                bsy  = 1'b0;
            end
            rd_data_pk[k*DATA_W +: DATA_W] = word;
            rd_busy_pk[k]                  = bsy;
        end
    end

    assign bus.rd_data  = rd_data_pk;
    assign bus.rd_busy  = rd_busy_pk;
    assign bus.busy_vec = busy_vec;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
// Four instances: A (bypass, no zero reg), B (no bypass), C (bypass, zero
// reg) share one 8-bit stimulus; D is the 16-bit / 32-entry / 3-read-port
// configuration. Table vectors cover A and B; hand sequences cover reset,
// zero register and the wide configuration.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Shared 8-bit stimulus
    logic [1:0] t_we;
    logic [2:0] t_wa0, t_wa1, t_ia, t_ra0, t_ra1;
    logic [7:0] t_wd0, t_wd1;
    logic       t_iv;

    // Wide-config stimulus
    logic [1:0]  d_we;
    logic [9:0]  d_wa;
    logic [31:0] d_wd;
    logic        d_iv;
    logic [4:0]  d_ia;
    logic [14:0] d_ra;

    regfile_if #(.DATA_W(8),  .ADDR_W(3), .NUM_RD(2)) if_a ();
    regfile_if #(.DATA_W(8),  .ADDR_W(3), .NUM_RD(2)) if_b ();
    regfile_if #(.DATA_W(8),  .ADDR_W(3), .NUM_RD(2)) if_c ();
    regfile_if #(.DATA_W(16), .ADDR_W(5), .NUM_RD(3)) if_d ();

    assign if_a.wr_en = t_we;  assign if_a.wr_addr = {t_wa1, t_wa0};
    assign if_a.wr_data = {t_wd1, t_wd0};  assign if_a.iss_valid = t_iv;
    assign if_a.iss_addr = t_ia;  assign if_a.rd_addr = {t_ra1, t_ra0};

    assign if_b.wr_en = t_we;  assign if_b.wr_addr = {t_wa1, t_wa0};
    assign if_b.wr_data = {t_wd1, t_wd0};  assign if_b.iss_valid = t_iv;
    assign if_b.iss_addr = t_ia;  assign if_b.rd_addr = {t_ra1, t_ra0};

    assign if_c.wr_en = t_we;  assign if_c.wr_addr = {t_wa1, t_wa0};
    assign if_c.wr_data = {t_wd1, t_wd0};  assign if_c.iss_valid = t_iv;
    assign if_c.iss_addr = t_ia;  assign if_c.rd_addr = {t_ra1, t_ra0};

    assign if_d.wr_en = d_we;  assign if_d.wr_addr = d_wa;
    assign if_d.wr_data = d_wd;  assign if_d.iss_valid = d_iv;
    assign if_d.iss_addr = d_ia;  assign if_d.rd_addr = d_ra;

    regfile_mp #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(0), .BYPASS(1))
        dut_a (.clk(clk), .reset_n(rst_n), .bus(if_a.slave));
    regfile_mp #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0))
        dut_b (.clk(clk), .reset_n(rst_n), .bus(if_b.slave));
    regfile_mp #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1))
        dut_c (.clk(clk), .reset_n(rst_n), .bus(if_c.slave));
    regfile_mp #(.DATA_W(16), .ADDR_W(5), .NUM_RD(3), .ZERO_REG(0), .BYPASS(1))
        dut_d (.clk(clk), .reset_n(rst_n), .bus(if_d.slave));

    int n_run  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] we, input logic [2:0] wa0, input logic [7:0] wd0,
                         input logic [2:0] wa1, input logic [7:0] wd1,
                         input logic iv, input logic [2:0] ia,
                         input logic [2:0] ra0, input logic [2:0] ra1);
        t_we = we; t_wa0 = wa0; t_wd0 = wd0; t_wa1 = wa1; t_wd1 = wd1;
        t_iv = iv; t_ia = ia; t_ra0 = ra0; t_ra1 = ra1;
    endtask

    typedef struct {
        logic [1:0] we;
        logic [2:0] wa0; logic [7:0] wd0;
        logic [2:0] wa1; logic [7:0] wd1;
        logic       iv;  logic [2:0] ia;
        logic [2:0] ra0; logic [2:0] ra1;
        logic [7:0] a_rd0; logic [7:0] a_rd1; logic [1:0] a_rb; logic [7:0] a_bv;
        logic [7:0] b_rd0; logic [1:0] b_rb;
    } vec_t;

    vec_t tbl [15];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          we     wa0  wd0    wa1  wd1    iv    ia   ra0  ra1   a_rd0  a_rd1  a_rb   a_bv   b_rd0  b_rb
        tbl[0]  = '{2'b01, 3'd5, 8'h07, 3'd0, 8'h00, 1'b0, 3'd0, 3'd5, 3'd1, 8'h07, 8'h00, 2'b00, 8'h00, 8'h00, 2'b00};
        tbl[1]  = '{2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b1, 3'd4, 3'd5, 3'd4, 8'h07, 8'h00, 2'b00, 8'h00, 8'h07, 2'b00};
        tbl[2]  = '{2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0, 3'd0, 3'd4, 3'd5, 8'h00, 8'h07, 2'b01, 8'h10, 8'h00, 2'b01};
        tbl[3]  = '{2'b10, 3'd0, 8'h00, 3'd4, 8'h33, 1'b0, 3'd0, 3'd4, 3'd4, 8'h33, 8'h33, 2'b00, 8'h10, 8'h00, 2'b11};
        tbl[4]  = '{2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0, 3'd0, 3'd4, 3'd5, 8'h33, 8'h07, 2'b00, 8'h00, 8'h33, 2'b00};
        tbl[5]  = '{2'b11, 3'd2, 8'h11, 3'd2, 8'h22, 1'b0, 3'd0, 3'd2, 3'd2, 8'h22, 8'h22, 2'b00, 8'h00, 8'h00, 2'b00};
        tbl[6]  = '{2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0, 3'd0, 3'd2, 3'd6, 8'h22, 8'h00, 2'b00, 8'h00, 8'h22, 2'b00};
        tbl[7]  = '{2'b01, 3'd5, 8'h80, 3'd0, 8'h00, 1'b0, 3'd0, 3'd5, 3'd2, 8'h80, 8'h22, 2'b00, 8'h00, 8'h07, 2'b00};
        tbl[8]  = '{2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0, 3'd0, 3'd5, 3'd0, 8'h80, 8'h00, 2'b00, 8'h00, 8'h80, 2'b00};
        tbl[9]  = '{2'b01, 3'd4, 8'h44, 3'd0, 8'h00, 1'b1, 3'd4, 3'd4, 3'd3, 8'h44, 8'h00, 2'b00, 8'h00, 8'h33, 2'b00};
        tbl[10] = '{2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0, 3'd0, 3'd4, 3'd4, 8'h44, 8'h44, 2'b11, 8'h10, 8'h44, 2'b11};
        tbl[11] = '{2'b01, 3'd6, 8'h5A, 3'd0, 8'h00, 1'b1, 3'd4, 3'd6, 3'd4, 8'h5A, 8'h44, 2'b10, 8'h10, 8'h00, 2'b10};
        tbl[12] = '{2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0, 3'd0, 3'd4, 3'd6, 8'h44, 8'h5A, 2'b01, 8'h10, 8'h44, 2'b01};
        tbl[13] = '{2'b00, 3'd6, 8'h99, 3'd4, 8'h77, 1'b0, 3'd0, 3'd6, 3'd4, 8'h5A, 8'h44, 2'b10, 8'h10, 8'h5A, 2'b10};
        tbl[14] = '{2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0, 3'd0, 3'd6, 3'd4, 8'h5A, 8'h44, 2'b10, 8'h10, 8'h5A, 2'b10};

        rst_n = 1'b0;
        drive(2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0);
        d_we = '0; d_wa = '0; d_wd = '0; d_iv = 1'b0; d_ia = '0; d_ra = '0;

        // Reset state, and writes/issues ignored while reset is held
        @(negedge clk);
        drive(2'b01, 3'd1, 8'hAB, 3'd0, 8'h00, 1'b1, 3'd1, 3'd1, 3'd0);
        #2;
        check("rst a_rd0", if_a.rd_data[7:0], 8'h00);
        check("rst a_rb", if_a.rd_busy, 2'b00);
        check("rst a_bv", if_a.busy_vec, 8'h00);
        @(negedge clk);
        drive(2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0, 3'd0, 3'd1, 3'd0);
        rst_n = 1'b1;
        #2;
        check("rst wr ignored a_rd0", if_a.rd_data[7:0], 8'h00);
        check("rst iss ignored a_bv", if_a.busy_vec, 8'h00);

        // Table-driven vectors
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(tbl[i].we, tbl[i].wa0, tbl[i].wd0, tbl[i].wa1, tbl[i].wd1,
                  tbl[i].iv, tbl[i].ia, tbl[i].ra0, tbl[i].ra1);
            #2;
            check($sformatf("v%0d a_rd0", i), if_a.rd_data[7:0],  tbl[i].a_rd0);
            check($sformatf("v%0d a_rd1", i), if_a.rd_data[15:8], tbl[i].a_rd1);
            check($sformatf("v%0d a_rb", i),  if_a.rd_busy,       tbl[i].a_rb);
            check($sformatf("v%0d a_bv", i),  if_a.busy_vec,      tbl[i].a_bv);
            check($sformatf("v%0d b_rd0", i), if_b.rd_data[7:0],  tbl[i].b_rd0);
            check($sformatf("v%0d b_rb", i),  if_b.rd_busy,       tbl[i].b_rb);
        end

        // Reset asserted mid-cycle discards contents and scoreboard at once
        @(negedge clk);
        drive(2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0, 3'd0, 3'd4, 3'd6);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst a_rd0", if_a.rd_data[7:0], 8'h00);
        check("midrst a_rd1", if_a.rd_data[15:8], 8'h00);
        check("midrst a_bv", if_a.busy_vec, 8'h00);
        check("midrst b_rd0", if_b.rd_data[7:0], 8'h00);
        drive(2'b01, 3'd3, 8'h5A, 3'd0, 8'h00, 1'b1, 3'd3, 3'd3, 3'd4);
        #1;
        check("midrst bypass blocked", if_a.rd_data[7:0], 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b01, 3'd3, 8'h5A, 3'd0, 8'h00, 1'b0, 3'd0, 3'd3, 3'd4);
        #2;
        check("post rst a_rd0 bypass", if_a.rd_data[7:0], 8'h5A);
        check("post rst r4 cleared", if_a.rd_data[15:8], 8'h00);
        check("post rst b_rd0 old", if_b.rd_data[7:0], 8'h00);
        @(negedge clk);
        drive(2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0, 3'd0, 3'd3, 3'd4);
        #2;
        check("post rst a r3", if_a.rd_data[7:0], 8'h5A);
        check("post rst b r3", if_b.rd_data[7:0], 8'h5A);
        check("post rst a_bv", if_a.busy_vec, 8'h00);

        // Zero register: write and issue r0
        @(negedge clk);
        drive(2'b01, 3'd0, 8'hFF, 3'd0, 8'h00, 1'b1, 3'd0, 3'd0, 3'd0);
        #2;
        check("zr c_rd0 same cycle", if_c.rd_data[7:0], 8'h00);
        check("zr a_rd0 same cycle", if_a.rd_data[7:0], 8'hFF);
        @(negedge clk);
        drive(2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd3);
        #2;
        check("zr c_rd0", if_c.rd_data[7:0], 8'h00);
        check("zr c_bv", if_c.busy_vec, 8'h00);
        check("zr c_rb", if_c.rd_busy, 2'b00);
        check("nozr a_rd0", if_a.rd_data[7:0], 8'hFF);
        check("nozr a_bv", if_a.busy_vec, 8'h01);
        check("nozr b_rd0", if_b.rd_data[7:0], 8'hFF);

        // Wide configuration: r31 via port 1, r30 untouched
        @(negedge clk);
        d_we = 2'b10;
        d_wa = {5'd31, 5'd30};
        d_wd = {16'h8001, 16'h1234};
        d_ra = {5'd31, 5'd31, 5'd31};
        #2;
        check("d bypass rd0", if_d.rd_data[15:0],  16'h8001);
        check("d bypass rd1", if_d.rd_data[31:16], 16'h8001);
        check("d bypass rd2", if_d.rd_data[47:32], 16'h8001);
        @(negedge clk);
        d_we = 2'b00;
        d_ra = {5'd31, 5'd30, 5'd31};
        #2;
        check("d rd0 r31", if_d.rd_data[15:0],  16'h8001);
        check("d rd1 r30", if_d.rd_data[31:16], 16'h0000);
        check("d rd2 r31", if_d.rd_data[47:32], 16'h8001);
        @(negedge clk);
        d_iv = 1'b1;
        d_ia = 5'd17;
        d_ra = {5'd0, 5'd0, 5'd17};
        #2;
        check("d iss latency", if_d.rd_busy, 3'b000);
        @(negedge clk);
        d_iv = 1'b0;
        #2;
        check("d bv r17", if_d.busy_vec, 32'h0002_0000);
        check("d rb r17", if_d.rd_busy, 3'b001);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the datapath, with two write ports, N combinational read ports, optional write-through bypass, optional hardwired-zero register 0 and a per-register busy scoreboard. Decode marks a destination busy at issue. Writeback clears it. Readers get the operand value plus a busy flag, so hazard logic can stall without keeping its own tracking.

## Interface
- DATA_W, 8, register width in bits (values are two's-complement signed)
- ADDR_W, 3, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports
- ZERO_REG, 0, 1 = register 0 always reads 0 and is never busy
- BYPASS, 1, 1 = a read of an address being written this cycle returns the incoming write data

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_en  in  2  per-write-port enable; port 1 is bit 1
- wr_addr  in  2*ADDR_W  write addresses; port p is slice [p*ADDR_W +: ADDR_W]
- wr_data  in  2*DATA_W  write data; port p is slice [p*DATA_W +: DATA_W]
- iss_valid  in  1  mark iss_addr busy
- iss_addr  in  ADDR_W  destination register being issued
- rd_addr  in  NUM_RD*ADDR_W  read addresses, packed as for wr_addr
- rd_data  out  NUM_RD*DATA_W  read data, packed
- rd_busy  out  NUM_RD  read register has an outstanding producer
- busy_vec  out  2**ADDR_W  raw scoreboard state

## Operation
- Storage: 2**ADDR_W words of DATA_W bits.
- Write: for each port p with wr_en[p]=1, mem[wr_addr[p]] takes wr_data[p] at the clock edge.
- Both write ports to the same address: port 1 wins.
- ZERO_REG=1: writes to address 0 are dropped, and rd_data for address 0 is 0.
- Read: rd_data[k] is combinational from rd_addr[k].
- BYPASS=1 with a write hit on that address in the same cycle: rd_data[k] returns the winning wr_data (port 1 over port 0).
- BYPASS=0: the read returns the stored (old) value.
- Scoreboard, busy[r], next state:
  - iss_valid && iss_addr==r: set to 1. Set beats clear, because a new producer supersedes the completing one.
  - otherwise, any enabled write port with wr_addr==r: clear to 0.
  - otherwise: hold.
- ZERO_REG=1: busy[0] is constant 0.
- rd_busy[k] = busy[rd_addr[k]] & ~(BYPASS && write hit on rd_addr[k] this cycle).
- Issuing to an already-busy register is legal; the bit stays 1.

## Timing
- Reset (reset_n=0, asynchronous): all words become 0 and all busy bits become 0.
- While reset is held:
  - rd_data = 0, rd_busy = 0, busy_vec = 0.
  - wr_en and iss_valid are ignored.
- Deassertion of reset is assumed synchronised upstream.
- Read latency is 0 cycles (combinational). The write-to-read latency is 0 cycles with BYPASS=1 and 1 cycle with BYPASS=0.
- Issue-to-busy latency is 1 cycle; busy_vec is registered.
- Writeback-to-not-busy is 0 cycles on rd_busy with BYPASS=1. busy_vec clears 1 cycle later.
- Reset asserted mid-operation discards all contents and scoreboard state immediately.
- No handshake on writes; they always complete in one cycle.

## Structure
- Package regfile_pkg holds:
  - default DATA_W/ADDR_W/NUM_RD constants
  - the functions for slicing packed port vectors.
- Sub-module regfile_scoreboard holds the busy[] register, the set/clear priority and the ZERO_REG masking. Its ports are clk, reset_n, the wr/iss inputs and busy_vec.
- The top level holds storage, write-port arbitration, the read muxes with bypass, and rd_busy masking.

## Test plan
- Reset then read: pulse reset_n low mid-run after writes → all rd_data=0, busy_vec=0, then a write of 0x5A to r3 reads back 0x5A.
- Dual-write conflict: port0 writes r2=0x11 and port1 writes r2=0x22 in the same cycle → next cycle r2 reads 0x22; with BYPASS=1 the same-cycle read also shows 0x22.
- Bypass vs. no bypass: write r5=0x80 (−128) while reading r5 (old 0x07) → BYPASS=1 shows 0x80 that cycle; BYPASS=0 shows 0x07 then 0x80.
- Zero register: ZERO_REG=1, write r0=0xFF and issue r0 → r0 reads 0, busy_vec[0]=0; with ZERO_REG=0, r0 reads 0xFF.
- Scoreboard: issue r4 → busy_vec[4]=1 next cycle; write r4 → rd_busy=0 same cycle (BYPASS=1) and busy_vec[4]=0 next cycle.
- Issue and write of r4 in the same cycle → busy_vec[4] stays 1.
- Width/port scaling: DATA_W=16, ADDR_W=5, NUM_RD=3 → write 0x8001 to r31 via port1; all three read ports return 0x8001 at the same address, and r30 is unaffected.
